// File: rtl/iob_prio_arbiter.sv
// rtl/iob_prio_arbiter.sv - registered N-channel priority/round-robin arbiter
//
// Purpose: grants one of N requesters a shared port.
//   The grant is held until the owner signals done_i.
//   After release the grant outputs are low for at least one cycle before the
//   next grant (bus turnaround).
//   Selection policy is set by MODE:
//     "LOW"  - lowest index wins
//     "HIGH" - highest index wins
//     "RR"   - round-robin starting from the pointer
//   Any other MODE string behaves as "HIGH".
//
// Optional feature: define IOB_PRIO_ARBITER_CNT_EN to add grant_cnt_o, a
//   16-bit wrapping count of grants issued.
//
// Ports:
//   clk_i          - clock, rising edge
//   arst_n_i       - asynchronous reset, active-low
//   cke_i          - clock enable; all state holds while low
//   req_i[N]       - request vector
//   done_i         - current owner finished (only looked at while busy)
//   grant_o[N]     - one-hot grant, registered
//   grant_idx_o    - encoded grant index, registered
//   grant_valid_o  - a grant is active
//   grant_cnt_o    - grants issued (only with IOB_PRIO_ARBITER_CNT_EN)

module iob_prio_arbiter #(
  parameter int    N     = 4,
  parameter string MODE  = "LOW",
  parameter int    W_IDX = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     grant_o,
  output logic [W_IDX-1:0] grant_idx_o,
`ifdef IOB_PRIO_ARBITER_CNT_EN
  output logic [15:0]      grant_cnt_o,
`endif
  output logic             grant_valid_o
);

  localparam bit IS_LOW = (MODE == "LOW");
  localparam bit IS_RR  = (MODE == "RR");

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [W_IDX-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [W_IDX-1:0] ptr_q, ptr_d;
  logic [W_IDX-1:0] win;
  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;

  // Rotating the request vector by the pointer turns round-robin into a
  // lowest-set-bit search that starts at ptr_q and wraps naturally.
  assign req_dbl = {req_i, req_i} >> ptr_q;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    logic [W_IDX:0] sum;
    win = '0;
    sum = '0;
    if (IS_LOW) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) win = W_IDX'(i);
      end
    end else if (IS_RR) begin
      for (int k = N - 1; k >= 0; k--) begin
        sum = {1'b0, ptr_q} + (W_IDX+1)'(k);
        if (sum >= (W_IDX+1)'(N)) sum = sum - (W_IDX+1)'(N);
        if (req_rot[k]) win = sum[W_IDX-1:0];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i]) win = W_IDX'(i);
      end
    end
  end

`ifdef IOB_PRIO_ARBITER_CNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef IOB_PRIO_ARBITER_CNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          idx_d        = win;
          valid_d      = 1'b1;
          state_d      = BUSY;
`ifdef IOB_PRIO_ARBITER_CNT_EN
          cnt_d        = cnt_q + 16'd1;
`endif
        end
      end
      BUSY: begin
        // Request changes are ignored here; only done_i ends ownership.
        // Returning to IDLE (with outputs cleared) is what provides the
        // guaranteed turnaround cycle.
        if (done_i) begin
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
          if (IS_RR) begin
            ptr_d = (idx_q == W_IDX'(N - 1)) ? '0 : idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef IOB_PRIO_ARBITER_CNT_EN
      cnt_q   <= '0;
`endif
    end else if (cke_i) begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef IOB_PRIO_ARBITER_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = valid_q;
`ifdef IOB_PRIO_ARBITER_CNT_EN
  assign grant_cnt_o   = cnt_q;
`endif

endmodule

// File: tb/tb_iob_prio_arbiter.sv
// tb/tb_iob_prio_arbiter.sv - self-checking bench for iob_prio_arbiter (LOW, HIGH, RR instances)

module tb_iob_prio_arbiter;

  logic       clk;
  logic       arst_n;
  logic [3:0] req  [3];
  logic       done [3];
  logic       cke  [3];
  logic [3:0] gg   [3];
  logic [1:0] gi   [3];
  logic       gv   [3];
`ifdef IOB_PRIO_ARBITER_CNT_EN
  logic [15:0] cnt [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic       v;
    logic [1:0] idx;
    logic [3:0] g;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iob_prio_arbiter #(.N(4), .MODE("LOW")) u_low (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[0]), .req_i(req[0]), .done_i(done[0]),
    .grant_o(gg[0]), .grant_idx_o(gi[0]),
`ifdef IOB_PRIO_ARBITER_CNT_EN
    .grant_cnt_o(cnt[0]),
`endif
    .grant_valid_o(gv[0])
  );

  iob_prio_arbiter #(.N(4), .MODE("HIGH")) u_high (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[1]), .req_i(req[1]), .done_i(done[1]),
    .grant_o(gg[1]), .grant_idx_o(gi[1]),
`ifdef IOB_PRIO_ARBITER_CNT_EN
    .grant_cnt_o(cnt[1]),
`endif
    .grant_valid_o(gv[1])
  );

  iob_prio_arbiter #(.N(4), .MODE("RR")) u_rr (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[2]), .req_i(req[2]), .done_i(done[2]),
    .grant_o(gg[2]), .grant_idx_o(gi[2]),
`ifdef IOB_PRIO_ARBITER_CNT_EN
    .grant_cnt_o(cnt[2]),
`endif
    .grant_valid_o(gv[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Push the expectation for the next edge, advance one cycle, then pop and
  // compare against instance d at the falling edge.
  task automatic cyc(input int d, input string tag, input logic v, input logic [1:0] i,
                     input logic [3:0] g);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    e.idx = i;
    e.g   = g;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".valid"}, 32'(gv[d]), 32'(e.v));
    check({e.tag, ".idx"},   32'(gi[d]), 32'(e.idx));
    check({e.tag, ".grant"}, 32'(gg[d]), 32'(e.g));
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, ".valid"}, 32'(gv[d]), 32'd0);
    check({tag, ".idx"},   32'(gi[d]), 32'd0);
    check({tag, ".grant"}, 32'(gg[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req[d]  = 4'b1111;
      done[d] = 1'b0;
      cke[d]  = 1'b1;
    end

    // Reset held with all requests active: nothing may be granted.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_zero(d, $sformatf("rst_hold%0d", d));

    for (int d = 0; d < 3; d++) req[d] = 4'b0000;
    arst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc(k % 3, $sformatf("idle%0d", k), 1'b0, 2'd0, 4'b0000);

    // LOW: lowest set bit wins, one idle cycle after release.
    req[0] = 4'b1010;
    cyc(0, "low_grant", 1'b1, 2'd1, 4'b0010);
    cyc(0, "low_hold",  1'b1, 2'd1, 4'b0010);
    done[0] = 1'b1;
    cyc(0, "low_rel",   1'b0, 2'd0, 4'b0000);
    done[0] = 1'b0;
    cyc(0, "low_regrant", 1'b1, 2'd1, 4'b0010);
    done[0] = 1'b1;
    req[0]  = 4'b0000;
    cyc(0, "low_rel2",  1'b0, 2'd0, 4'b0000);
    cyc(0, "low_done_idle", 1'b0, 2'd0, 4'b0000);
    done[0] = 1'b0;
    // done together with a new request: release first, serve afterwards.
    req[0] = 4'b1000;
    cyc(0, "low_g3", 1'b1, 2'd3, 4'b1000);
    req[0]  = 4'b0011;
    done[0] = 1'b1;
    cyc(0, "low_done_req", 1'b0, 2'd0, 4'b0000);
    done[0] = 1'b0;
    cyc(0, "low_after_turn", 1'b1, 2'd0, 4'b0001);
    done[0] = 1'b1;
    req[0]  = 4'b0000;
    cyc(0, "low_rel3", 1'b0, 2'd0, 4'b0000);
    done[0] = 1'b0;

    // HIGH: highest set bit wins; grant held while the request drops.
    req[1] = 4'b0110;
    cyc(1, "high_grant", 1'b1, 2'd2, 4'b0100);
    req[1] = 4'b0000;
    for (int k = 0; k < 10; k++) cyc(1, $sformatf("high_hold%0d", k), 1'b1, 2'd2, 4'b0100);
    done[1] = 1'b1;
    cyc(1, "high_rel", 1'b0, 2'd0, 4'b0000);
    done[1] = 1'b0;
    req[1]  = 4'b1111;
    cyc(1, "high_all", 1'b1, 2'd3, 4'b1000);
    done[1] = 1'b1;
    req[1]  = 4'b0000;
    cyc(1, "high_rel2", 1'b0, 2'd0, 4'b0000);
    done[1] = 1'b0;

    // RR: rotating winners with one idle cycle between each.
    req[2] = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cyc(2, $sformatf("rr_g%0d", k), 1'b1, 2'(k), 4'(1 << k));
      done[2] = 1'b1;
      cyc(2, $sformatf("rr_idle%0d", k), 1'b0, 2'd0, 4'b0000);
      done[2] = 1'b0;
    end
    req[2] = 4'b0001;
    cyc(2, "rr_after3", 1'b1, 2'd0, 4'b0001);
    done[2] = 1'b1;
    cyc(2, "rr_rel_a", 1'b0, 2'd0, 4'b0000);
    done[2] = 1'b0;
    // Pointer is now 1: only channel 0 requesting forces a wrap.
    cyc(2, "rr_wrap", 1'b1, 2'd0, 4'b0001);
    done[2] = 1'b1;
    req[2]  = 4'b1001;
    cyc(2, "rr_rel_b", 1'b0, 2'd0, 4'b0000);
    done[2] = 1'b0;
    // Pointer is 1 again: scan 1,2,3 finds 3 before wrapping to 0.
    cyc(2, "rr_skip", 1'b1, 2'd3, 4'b1000);
    done[2] = 1'b1;
    req[2]  = 4'b0000;
    cyc(2, "rr_rel_c", 1'b0, 2'd0, 4'b0000);
    done[2] = 1'b0;

    // Clock enable freezes everything.
    cke[0] = 1'b0;
    req[0] = 4'b0100;
    cyc(0, "cke_idle0", 1'b0, 2'd0, 4'b0000);
    cyc(0, "cke_idle1", 1'b0, 2'd0, 4'b0000);
    cke[0] = 1'b1;
    cyc(0, "cke_grant", 1'b1, 2'd2, 4'b0100);
    cke[0]  = 1'b0;
    done[0] = 1'b1;
    cyc(0, "cke_busy0", 1'b1, 2'd2, 4'b0100);
    cyc(0, "cke_busy1", 1'b1, 2'd2, 4'b0100);
    cke[0] = 1'b1;
    req[0] = 4'b0000;
    cyc(0, "cke_rel", 1'b0, 2'd0, 4'b0000);
    done[0] = 1'b0;

`ifdef IOB_PRIO_ARBITER_CNT_EN
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    check("cnt_rst", 32'(cnt[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      req[0] = 4'b0001;
      cyc(0, $sformatf("cnt_g%0d", k), 1'b1, 2'd0, 4'b0001);
      done[0] = 1'b1;
      req[0]  = 4'b0000;
      cyc(0, $sformatf("cnt_r%0d", k), 1'b0, 2'd0, 4'b0000);
      done[0] = 1'b0;
    end
    check("cnt_three", 32'(cnt[0]), 32'd3);
`endif

    // Asynchronous reset in the middle of a grant.
    req[0] = 4'b0001;
    cyc(0, "arst_pre", 1'b1, 2'd0, 4'b0001);
    #1;
    arst_n = 1'b0;
    #1;
    check_zero(0, "arst_mid");
`ifdef IOB_PRIO_ARBITER_CNT_EN
    check("arst_cnt", 32'(cnt[0]), 32'd0);
`endif
    req[0] = 4'b0000;
    @(negedge clk);
    arst_n = 1'b1;
    cyc(0, "arst_post", 1'b0, 2'd0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
